// File: rtl/server_pkt_arbiter_pkg.sv
// Shared definitions for the server packet arbiter and other multi-port server blocks:
// arbiter FSM state encodings and the per-port statistics counter width.
package server_pkt_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_XFER = 2'b01
    } arb_state_e;

    localparam int ARB_CNT_W = 32;

endpackage

// File: rtl/server_rr_picker.sv
// Combinational round-robin picker: returns the first requesting port after last_grant,
// wrapping modulo NUM_PORTS, plus a valid flag when any port requests.
module server_rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PTR_W-1:0]     i_last_grant,
    output logic [PTR_W-1:0]     o_idx,
    output logic                 o_valid
);

    int               cand_s;
    logic [PTR_W-1:0] cand_idx_s;

    // Scan from the farthest offset to the nearest so the closest requester after last_grant wins.
    always_comb begin
        o_idx      = '0;
        o_valid    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            cand_s     = (int'(i_last_grant) + k) % NUM_PORTS;
            cand_idx_s = cand_s[PTR_W-1:0];
            o_idx      = i_req[cand_idx_s] ? cand_idx_s : o_idx;
            o_valid    = i_req[cand_idx_s] | o_valid;
        end
    end

endmodule

// File: rtl/server_pkt_arbiter.sv
// Packet-granular round-robin arbiter draining per-port FIFOs onto one AXI-Stream master.
// Optional per-port packet counters on o_pkt_cnt when SERVER_ARB_STATS_EN is defined.
module server_pkt_arbiter
    import server_pkt_arbiter_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_PORTS            = 4,
    parameter int PTR_W                = $clog2(NUM_PORTS)
) (
    input  logic                                          axis_aclk,
    input  logic                                          axis_reset,
    input  logic [NUM_PORTS-1:0]                          i_fifo_empty,
    output logic [NUM_PORTS-1:0]                          o_fifo_rd_en,
    input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      i_fifo_tdata,
    input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     i_fifo_tuser,
    input  logic [NUM_PORTS*(C_S_AXIS_DATA_WIDTH/8)-1:0]  i_fifo_tkeep,
    input  logic [NUM_PORTS-1:0]                          i_fifo_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
    output logic                                          m_axis_tlast,
    output logic                                          m_axis_tvalid,
    input  logic                                          m_axis_tready,
    output logic                                          o_busy,
`ifdef SERVER_ARB_STATS_EN
    output logic [NUM_PORTS*ARB_CNT_W-1:0]                o_pkt_cnt,
`endif
    output logic [PTR_W-1:0]                              o_grant
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] last_grant_q, last_grant_d;
    logic             busy_q, busy_d;

    logic [NUM_PORTS-1:0] req_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic                 pick_valid_s;
    logic                 xfer_s;
    logic                 pop_s;

    assign req_s = ~i_fifo_empty;

    server_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .i_req        (req_s),
        .i_last_grant (last_grant_q),
        .o_idx        (pick_idx_s),
        .o_valid      (pick_valid_s)
    );

    // Zero-latency beat mux from the granted FIFO head; everything forced to zero outside XFER.
    always_comb begin
        xfer_s        = (state_q == ARB_XFER);
        m_axis_tvalid = xfer_s & ~i_fifo_empty[grant_q];
        if (xfer_s) begin
            m_axis_tdata = i_fifo_tdata[grant_q*DW +: DW];
            m_axis_tuser = i_fifo_tuser[grant_q*UW +: UW];
            m_axis_tkeep = i_fifo_tkeep[grant_q*KW +: KW];
            m_axis_tlast = i_fifo_tlast[grant_q];
        end else begin
            m_axis_tdata = '0;
            m_axis_tuser = '0;
            m_axis_tkeep = '0;
            m_axis_tlast = 1'b0;
        end
        pop_s        = m_axis_tvalid & m_axis_tready;
        o_fifo_rd_en = pop_s ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q) : '0;
    end

    // Next-state logic: one arbitration cycle in IDLE, grant locked until a tlast handshake.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_d      = ARB_XFER;
                    grant_d      = pick_idx_s;
                    last_grant_d = pick_idx_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_XFER: begin
                if (pop_s && m_axis_tlast) begin
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_XFER;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d == ARB_XFER);
    end

    // FSM and registered status outputs.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= PTR_W'(NUM_PORTS - 1);
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_grant = grant_q;

`ifdef SERVER_ARB_STATS_EN
    logic [NUM_PORTS*ARB_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count accepted tlast beats per port; counters wrap naturally.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pop_s && m_axis_tlast) begin
            pkt_cnt_d[grant_q*ARB_CNT_W +: ARB_CNT_W] =
                pkt_cnt_q[grant_q*ARB_CNT_W +: ARB_CNT_W] + ARB_CNT_W'(1);
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: doc/server_pkt_arbiter.md
# server_pkt_arbiter

Packet-granular round-robin arbiter that drains the per-port `fallthrough_small_fifo` instances behind the server ingress filters (`server_op*_in`) onto a single AXI-Stream master toward the server processing pipeline. It watches each FIFO's empty flag and grants one port at a time. It holds the grant for the whole packet, until a `tlast` beat is accepted, so beats from different ports never interleave. It drives the FIFOs' `rd_en` directly, with zero added data latency.

## Interface
- `C_S_AXIS_DATA_WIDTH`, 256, tdata width
- `C_S_AXIS_TUSER_WIDTH`, 128, tuser width
- `NUM_PORTS`, 4, number of input FIFOs (2..8)
- `PTR_W`, $clog2(NUM_PORTS), grant index width (derived)

Ports:
- `axis_aclk`  in  1  clock
- `axis_reset`  in  1  reset; synchronous, active-high
- `i_fifo_empty`  in  NUM_PORTS  per-port FIFO empty flag
- `o_fifo_rd_en`  out  NUM_PORTS  per-port pop; one-hot or zero
- `i_fifo_tdata`  in  NUM_PORTS*DATA_W  flattened dout data; port p at [p*W +: W]
- `i_fifo_tuser`  in  NUM_PORTS*TUSER_W  flattened tuser
- `i_fifo_tkeep`  in  NUM_PORTS*DATA_W/8  flattened tkeep
- `i_fifo_tlast`  in  NUM_PORTS  tlast per port
- `m_axis_tdata` / `m_axis_tuser` / `m_axis_tkeep` / `m_axis_tlast`  out  as above  selected beat
- `m_axis_tvalid`  out  1  beat valid
- `m_axis_tready`  in  1  downstream ready
- `o_busy`  out  1  high in XFER
- `o_grant`  out  PTR_W  current or last granted port

## Operation
- FSM states:
  - IDLE (2'b00):
    - If any `!i_fifo_empty[p]`, select the first non-empty port in round-robin order starting at `last_grant+1` (mod NUM_PORTS).
    - Register it into `grant` and `last_grant`, then go to XFER.
    - Otherwise stay in IDLE.
  - XFER (2'b01):
    - `m_axis_tvalid = !i_fifo_empty[grant]`.
    - Data, user, keep and last are muxed combinationally from port `grant`.
    - `o_fifo_rd_en[grant] = m_axis_tvalid & m_axis_tready`; all other bits are 0.
    - On a handshake with tlast=1, go to IDLE.
- Empty mid-packet: keep the grant and drive tvalid low. No timeout; the lock persists until tlast.
- tvalid and data outside XFER: 0, with muxed outputs forced to zero. `o_fifo_rd_en` is all-zero in IDLE.
- Data fields must not change while tvalid=1 and tready=0. This holds because the FIFO head is stable until popped.
- Fairness: a port that just finished is lowest priority in the next IDLE arbitration.
- `o_grant` = `grant` register, reset 0. `o_busy` = (state==XFER).
- Reset values:
  - state IDLE, `grant` 0, `last_grant` NUM_PORTS-1, so port 0 wins first.
  - All outputs 0. Stats counters (if present) 0.
- Reset mid-packet: FSM returns to IDLE immediately. The remaining beats are still in the FIFOs; clearing them is the FIFOs' own reset duty.

## Timing
- Arbitration costs exactly 1 cycle: IDLE cycle, then the first beat may be presented the following cycle.
- Back-to-back packets: one bubble cycle between tlast handshake and next packet's first beat.
- Data path is combinational from FIFO dout to `m_axis_*`; 0 cycles of latency per beat.
- Sustained throughput: 1 beat/cycle within a packet while FIFO non-empty and tready=1.
- Simultaneous requests: exactly one grant per IDLE cycle. Requests arriving during XFER wait.

## Configuration
- `SERVER_ARB_STATS_EN` defined:
  - Adds output `o_pkt_cnt` [NUM_PORTS*32], one 32-bit counter per port.
  - A port's counter increments on each accepted tlast beat from that port and wraps modulo 2^32.
  - Counters clear on `axis_reset`.
- Not defined: the port and counters do not exist; all other behaviour is identical.

## Structure
- Shared defines header alongside `IPPROT_UDP`/`DST_PORT` holds:
  - the FSM state encodings `ARB_IDLE` and `ARB_XFER`;
  - the counter width `ARB_CNT_W`=32.
- One sub-module: `server_rr_picker`. Combinational; inputs request vector and last_grant; outputs index and valid. It is reused by any future multi-port server block.

## Test plan
- Single port, 3-beat packet on port 2 with tready=1 → `o_grant`=2 after the 1-cycle IDLE. Three beats out on consecutive cycles, `rd_en`=4'b0100 each, tlast on beat 3, `o_busy` falls the next cycle.
- Ports 0, 1, 3 each hold one 2-beat packet at reset release → output order is port 0, 1, 3, with a 1-cycle bubble between packets and no interleaving.
- tready toggling 1,0,0,1 mid-packet → `rd_en` asserts only on tready=1 cycles; tdata is stable across stalls; the beat count out equals the beat count in.
- Port 1 FIFO empties after beat 1 of a 4-beat packet while port 0 has data → tvalid=0 and grant held at 1; port 0 is not served until port 1's tlast is accepted.
- `axis_reset` asserted during beat 2 of a packet → next cycle IDLE, all outputs 0, `o_grant`=0. The first grant after reset goes to the lowest non-empty port.
- With `SERVER_ARB_STATS_EN`: five packets from port 3 and two from port 0 → `o_pkt_cnt` port3=5, port0=2, others 0. A preload of 32'hFFFFFFFF plus one packet wraps to 0.
